bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from any BCD digit ≥ 8.
- Inverse of the team's binary-to-BCD decoder.
- Converts packed BCD values (e.g. operator-entered phase durations, 0..99 s) back to binary for the traffic-light countdown timers.
- Single-request start/done handshake; one conversion in flight.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd2bin_seq_if.sv | 32 +++
 rtl/bcd_digit_adj.sv | 22 ++
 rtl/bcd2bin_seq.sv | 142 ++++++++++++++
 tb/tb_bcd2bin_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : bcd_pkg                                                      |
// | Purpose   : Shared types and digit constants for the BCD <-> binary      |
// |             converters (this converter and the binary-to-BCD decoder).   |
// | Contents  : state_e FSM encoding, digit limit/adjust constants,          |
// |             digit_illegal() helper.                                      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [3:0] DIGIT_MAX  = 4'd9;
   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_VAL    = 4'd3;

   // A packed BCD digit is only legal in the range 0..9.
   function automatic logic digit_illegal(input logic [3:0] d);
      return d > DIGIT_MAX;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2bin_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : bcd2bin_seq_if                                               |
// | Purpose   : start/done handshake and data bus of the BCD-to-binary       |
// |             converter.                                                   |
// | Signals   : start (req), bcd (packed BCD, digit 0 in [3:0]),             |
// |             ready (idle), done (1-cycle result strobe), bin (result),    |
// |             err (illegal-digit flag).                                    |
// | Modports  : master = requester, slave = converter.                       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface bcd2bin_seq_if #(
   parameter int DIGITS = 2
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ready;
   logic                  done;
   logic [4*DIGITS-1:0]   bin;
   logic                  err;

   modport master (
      output start, bcd,
      input  ready, done, bin, err
   );

   modport slave (
      input  start, bcd,
      output ready, done, bin, err
   );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : bcd_digit_adj                                                |
// | Purpose   : Reverse double-dabble digit correction. After a right shift  |
// |             a digit that received the LSB of its upper neighbour holds   |
// |             value+8; subtracting 3 restores the decimal weight (10/2=5). |
// | Ports     : i_digit [3:0] in  - shifted BCD digit                        |
// |             o_digit [3:0] out - corrected digit                          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   // Only applied when i_digit >= 8, so the subtraction cannot underflow.
   assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_VAL) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : bcd2bin_seq                                                  |
// | Purpose   : Sequential packed-BCD to binary converter (reverse double    |
// |             dabble): one right shift + per-digit adjust per cycle,       |
// |             4*DIGITS iterations per conversion, one conversion in flight.|
// | Ports     : clk  in  - system clock, rising edge                         |
// |             rst  in  - synchronous active-high reset                     |
// |             bus  slave modport of bcd2bin_seq_if (start/bcd in,          |
// |                  ready/done/bin/err out)                                 |
// | Options   : BCD_CHECK_EN - when defined, input digits > 9 are flagged;   |
// |             the result is then bin=0, err=1. When undefined err is 0.    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic          clk,
   input  logic          rst,
   bcd2bin_seq_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int BIN_W = 4 * DIGITS;
   localparam int ITER  = 4 * DIGITS;
   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   state_e                   state_q, state_d;
   logic [BCD_W+BIN_W-1:0]   sreg_q,  sreg_d;
   logic [CNT_W-1:0]         cnt_q,   cnt_d;
   logic [BIN_W-1:0]         bin_q,   bin_d;

   logic [BCD_W+BIN_W-1:0]   w_shift;
   logic [BCD_W-1:0]         w_adj_bcd;
   logic [BCD_W+BIN_W-1:0]   w_step;

   // Working register is {bcd_part, bin_part}; shifting right moves the
   // BCD value's LSBs into the binary half one bit per cycle.
   assign w_shift = sreg_q >> 1;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (w_shift[BIN_W + 4*gi +: 4]),
         .o_digit (w_adj_bcd[4*gi +: 4])
      );
   end

   assign w_step = {w_adj_bcd, w_shift[BIN_W-1:0]};

`ifdef BCD_CHECK_EN
   logic flag_q, flag_d;
   logic err_q,  err_d;
   logic w_bad;

   always_comb begin
      w_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_illegal(bus.bcd[4*i +: 4])) begin
            w_bad = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
`ifdef BCD_CHECK_EN
      flag_d  = flag_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sreg_d  = {bus.bcd, {BIN_W{1'b0}}};
               cnt_d   = '0;
`ifdef BCD_CHECK_EN
               flag_d  = w_bad;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = w_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
`ifdef BCD_CHECK_EN
               bin_d   = flag_q ? '0 : w_step[BIN_W-1:0];
               err_d   = flag_q;
`else
               bin_d   = w_step[BIN_W-1:0];
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
`ifdef BCD_CHECK_EN
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
`ifdef BCD_CHECK_EN
         flag_q  <= flag_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.bin   = bin_q;
`ifdef BCD_CHECK_EN
   assign bus.err   = err_q;
`else
   assign bus.err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_bcd2bin_seq                                               |
// | Purpose   : Self-checking bench for bcd2bin_seq, DIGITS=2 and DIGITS=3   |
// |             instances. A decimal-value model predicts ready/done/bin/err |
// |             every cycle; directed conversions pin literal results.       |
// | Options   : BCD_CHECK_EN - enables the illegal-digit scenario.           |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bcd2bin_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd2bin_seq_if #(.DIGITS(2)) if2 ();
   bcd2bin_seq_if #(.DIGITS(3)) if3 ();

   bcd2bin_seq #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
   bcd2bin_seq #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

   int errors = 0;
   int checks = 0;

   // model state per unit (0: DIGITS=2, 1: DIGITS=3)
   bit          m_valid  [2];
   bit          m_busy   [2];
   int          m_age    [2];
   logic [15:0] m_bin    [2];
   logic        m_err    [2];
   bit          m_ign    [2];
   logic [15:0] m_pbin   [2];
   logic        m_perr   [2];
   bit          m_pign   [2];
   int          n_done   [2];

   logic        s_start  [2];
   logic [15:0] s_bcd    [2];
   logic        d_ready  [2];
   logic        d_done   [2];
   logic [15:0] d_bin    [2];
   logic        d_err    [2];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Decimal value of a packed BCD word, computed digit by digit.
   function automatic void model_conv(input logic [15:0] v, input int nd,
                                      output logic [15:0] b, output logic e, output bit ign);
      int acc;
      bit bad;
      acc = 0;
      bad = 0;
      for (int i = nd - 1; i >= 0; i--) begin
         int d;
         d = int'(v[4*i +: 4]);
         if (d > 9) bad = 1;
         acc = acc * 10 + d;
      end
`ifdef BCD_CHECK_EN
      b   = bad ? 16'd0 : 16'(acc);
      e   = bad;
      ign = 0;
`else
      b   = 16'(acc);
      e   = 1'b0;
      ign = bad;
`endif
   endfunction

   // Compare then advance the model; inputs are stable at the negedge and
   // are what the next rising edge samples.
   always @(negedge clk) begin
      s_start[0] = if2.start;  s_bcd[0] = 16'(if2.bcd);
      s_start[1] = if3.start;  s_bcd[1] = 16'(if3.bcd);
      d_ready[0] = if2.ready;  d_done[0] = if2.done;  d_bin[0] = 16'(if2.bin);  d_err[0] = if2.err;
      d_ready[1] = if3.ready;  d_done[1] = if3.done;  d_bin[1] = 16'(if3.bin);  d_err[1] = if3.err;
      for (int u = 0; u < 2; u++) begin
         int iter;
         iter = (u == 0) ? 8 : 12;
         if (m_valid[u]) begin
            chk($sformatf("u%0d ready", u), 16'(d_ready[u]), 16'(!m_busy[u]));
            chk($sformatf("u%0d done", u), 16'(d_done[u]), 16'(m_busy[u] && m_age[u] == iter));
            if (!m_ign[u]) chk($sformatf("u%0d bin", u), d_bin[u], m_bin[u]);
            chk($sformatf("u%0d err", u), 16'(d_err[u]), 16'(m_err[u]));
            if (d_done[u] === 1'b1) n_done[u]++;
         end
         if (rst) begin
            m_valid[u] = 1;
            m_busy[u]  = 0;
            m_age[u]   = 0;
            m_bin[u]   = '0;
            m_err[u]   = 1'b0;
            m_ign[u]   = 0;
         end else if (m_valid[u]) begin
            if (m_busy[u]) begin
               m_age[u]++;
               if (m_age[u] == iter) begin
                  m_bin[u] = m_pbin[u];
                  m_err[u] = m_perr[u];
                  m_ign[u] = m_pign[u];
               end
               if (m_age[u] == iter + 1) m_busy[u] = 0;
            end else if (s_start[u] === 1'b1) begin
               m_busy[u] = 1;
               m_age[u]  = 0;
               model_conv(s_bcd[u], (u == 0) ? 2 : 3, m_pbin[u], m_perr[u], m_pign[u]);
            end
         end
      end
   end

   task automatic drive(input int u, input logic s, input logic [15:0] v);
      if (u == 0) begin
         if2.start = s;
         if2.bcd   = v[7:0];
      end else begin
         if3.start = s;
         if3.bcd   = v[11:0];
      end
   endtask

   function automatic logic get_ready(input int u);
      return (u == 0) ? if2.ready : if3.ready;
   endfunction

   function automatic logic get_done(input int u);
      return (u == 0) ? if2.done : if3.done;
   endfunction

   function automatic logic [15:0] get_bin(input int u);
      return (u == 0) ? 16'(if2.bin) : 16'(if3.bin);
   endfunction

   function automatic logic get_err(input int u);
      return (u == 0) ? if2.err : if3.err;
   endfunction

   // One conversion: pulse start for one cycle, then wait (bounded) for done.
   task automatic conv(input int u, input logic [15:0] v, input logic [15:0] lit,
                       input logic lit_err, input string nm);
      int  n;
      bit  seen;
      int  iter;
      iter = (u == 0) ? 8 : 12;
      @(posedge clk); #1;
      drive(u, 1'b1, v);
      @(posedge clk); #1;
      drive(u, 1'b0, (u == 0) ? 16'h0077 : 16'h0777);   // bcd churn during SHIFT
      @(negedge clk);
      chk({nm, " ready_drop"}, 16'(get_ready(u)), 16'd0);
      n    = 1;
      seen = 0;
      while (!seen && n < 40) begin
         if (get_done(u) === 1'b1) seen = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk({nm, " latency"}, 16'(n), 16'(iter + 1));
      chk({nm, " bin"}, get_bin(u), lit);
      chk({nm, " err"}, 16'(get_err(u)), 16'(lit_err));
      @(negedge clk);
      chk({nm, " ready_back"}, 16'(get_ready(u)), 16'd1);
   endtask

   initial begin
      int nd0;
      drive(0, 1'b0, 16'h0);
      drive(1, 1'b0, 16'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst ready", 16'(if2.ready), 16'd1);
      chk("rst done",  16'(if2.done),  16'd0);
      chk("rst bin",   16'(if2.bin),   16'd0);
      chk("rst err",   16'(if2.err),   16'd0);
      chk("rst3 bin",  16'(if3.bin),   16'd0);

      conv(0, 16'h0099, 16'd99, 1'b0, "c99");
      conv(0, 16'h0000, 16'd0,  1'b0, "c00");
      conv(0, 16'h0047, 16'd47, 1'b0, "c47");
      conv(0, 16'h0010, 16'd10, 1'b0, "c10");
      repeat (5) @(negedge clk);
      chk("hold10 bin", 16'(if2.bin), 16'd10);

      // start held high: back-to-back conversions every ITER+2 cycles
      nd0 = n_done[0];
      @(posedge clk); #1;
      if2.start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if2.bcd = (i % 2) ? 8'h60 : 8'h25;
         repeat (4) @(posedge clk);
         #1 if2.bcd = 8'h88;
         repeat (6) @(posedge clk);
         #1;
         chk($sformatf("b2b%0d bin", i), 16'(if2.bin), (i % 2) ? 16'd60 : 16'd25);
      end
      if2.start = 1'b0;
      chk("b2b done count", 16'(n_done[0] - nd0), 16'd6);

      // reset in the middle of a conversion aborts it
      @(posedge clk); #1;
      drive(0, 1'b1, 16'h0099);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0000);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort ready", 16'(if2.ready), 16'd1);
      chk("abort done",  16'(if2.done),  16'd0);
      chk("abort bin",   16'(if2.bin),   16'd0);
      nd0 = n_done[0];
      repeat (15) @(negedge clk);
      chk("abort no_done", 16'(n_done[0] - nd0), 16'd0);
      conv(0, 16'h0012, 16'd12, 1'b0, "c12");

`ifdef BCD_CHECK_EN
      conv(0, 16'h003A, 16'd0,  1'b1, "c3A");
`endif
      conv(0, 16'h0038, 16'd38, 1'b0, "c38");

      conv(1, 16'h0999, 16'd999, 1'b0, "d999");
      conv(1, 16'h0100, 16'd100, 1'b0, "d100");
      conv(1, 16'h0305, 16'd305, 1'b0, "d305");

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
